// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM and ALU decoder for the multicycle MIPS core (lw/sw/R-type/beq/addi/j).
// Latency: Moore outputs from the state register; pcen, illegal and alucontrol are combinational.
// Backpressure: none; the FSM advances one state per clock, and reset abandons the current instruction.
module mips_multicycle_ctrl #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               pcen,
   output logic               memwrite,
   output logic               irwrite,
   output logic               iord,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [2:0]         alucontrol,
   output logic               illegal,
   output logic [STATE_W-1:0] dbg_state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [STATE_W-1:0] {
      FETCH  = STATE_W'(0),
      DECODE = STATE_W'(1),
      MEMADR = STATE_W'(2),
      MEMRD  = STATE_W'(3),
      MEMWB  = STATE_W'(4),
      MEMWR  = STATE_W'(5),
      RTEX   = STATE_W'(6),
      RTWB   = STATE_W'(7),
      BEQEX  = STATE_W'(8),
      ADDIEX = STATE_W'(9),
      ADDIWB = STATE_W'(10),
      JEX    = STATE_W'(11)
   } state_t;

   typedef struct packed {
      logic       iord;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       memwrite;
      logic       irwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       pcwrite;
      logic       branch;
   } ctrl_t;

   state_t state;
   state_t state_nxt;
   ctrl_t  ctrl;
   logic   bad_op;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = FETCH;
      ctrl      = '0;
      bad_op    = 1'b0;
      case (state)
         FETCH: begin
            ctrl.alusrcb = 2'b01;
            ctrl.irwrite = 1'b1;
            ctrl.pcwrite = 1'b1;
            state_nxt    = DECODE;
         end
         DECODE: begin
            ctrl.alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_RTYPE:     state_nxt = RTEX;
               OP_BEQ:       state_nxt = BEQEX;
               OP_ADDI:      state_nxt = ADDIEX;
               OP_J:         state_nxt = JEX;
               default: begin
                  state_nxt = FETCH;
                  bad_op    = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = 2'b10;
            state_nxt    = (op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            ctrl.iord = 1'b1;
            state_nxt = MEMWB;
         end
         MEMWB: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         RTEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = 2'b10;
            state_nxt    = RTWB;
         end
         RTWB: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         BEQEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = 2'b01;
            ctrl.pcsrc   = 2'b01;
            ctrl.branch  = 1'b1;
         end
         ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = 2'b10;
            state_nxt    = ADDIWB;
         end
         ADDIWB: begin
            ctrl.regwrite = 1'b1;
         end
         JEX: begin
            ctrl.pcsrc   = 2'b10;
            ctrl.pcwrite = 1'b1;
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_comb begin
      alucontrol = 3'b010;
      case (ctrl.aluop)
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

   // Every state-changing strobe is gated by reset so an abandoned instruction cannot commit.
   assign pcen      = (ctrl.pcwrite | (ctrl.branch & zero)) & ~reset;
   assign memwrite  = ctrl.memwrite & ~reset;
   assign irwrite   = ctrl.irwrite & ~reset;
   assign regwrite  = ctrl.regwrite & ~reset;
   assign illegal   = bad_op & ~reset;
   assign iord      = ctrl.iord;
   assign regdst    = ctrl.regdst;
   assign memtoreg  = ctrl.memtoreg;
   assign alusrca   = ctrl.alusrca;
   assign alusrcb   = ctrl.alusrcb;
   assign pcsrc     = ctrl.pcsrc;
   assign dbg_state = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table plus random instruction streams
// checked against a per-instruction state-path model.
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;
   localparam logic [5:0] SLT  = 6'b101010;
   localparam logic [5:0] FAND = 6'b100100;

   logic       clk = 1'b0;
   logic       reset, zero;
   logic [5:0] op, funct;
   logic       pcen, memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] dbg_state;

   mips_multicycle_ctrl #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .iord(iord),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .alucontrol(alucontrol), .illegal(illegal), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // {pcen,memwrite,irwrite,iord,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,illegal}
   function automatic logic [15:0] obs();
      return {pcen, memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca,
              alusrcb, pcsrc, alucontrol, illegal};
   endfunction

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic [3:0]  st;
      logic [15:0] exp;
   } vec_t;

   function automatic vec_t v(input logic rst, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input int st,
                              input logic pe, input logic mw, input logic irw, input logic io,
                              input logic rd, input logic m2r, input logic rw, input logic asa,
                              input logic [1:0] asb, input logic [1:0] pcs,
                              input logic [2:0] alc, input logic ill);
      vec_t r;
      r.rst = rst; r.op = o; r.funct = f; r.zero = z; r.st = 4'(st);
      r.exp = {pe, mw, irw, io, rd, m2r, rw, asa, asb, pcs, alc, ill};
      return r;
   endfunction

   // Spec-level model: each instruction class walks a fixed path of states.
   function automatic int path_len(input logic [5:0] o);
      case (o)
         LW:           return 5;
         SW, RT, ADDI: return 4;
         BEQ, JMP:     return 3;
         default:      return 2;
      endcase
   endfunction

   function automatic int path_state(input logic [5:0] o, input int k);
      int p[5];
      case (o)
         LW:      p = '{0, 1, 2, 3, 4};
         SW:      p = '{0, 1, 2, 5, 0};
         RT:      p = '{0, 1, 6, 7, 0};
         ADDI:    p = '{0, 1, 9, 10, 0};
         BEQ:     p = '{0, 1, 8, 0, 0};
         JMP:     p = '{0, 1, 11, 0, 0};
         default: p = '{0, 1, 0, 0, 0};
      endcase
      return p[k];
   endfunction

   function automatic logic [15:0] model(input int st, input logic [5:0] o, input logic [5:0] f,
                                         input logic z, input logic rst);
      logic pw, br, mw, irw, io, rd, m2r, rw, asa, ill;
      logic [1:0] asb, pcs, aop;
      logic [2:0] alc;
      {pw, br, mw, irw, io, rd, m2r, rw, asa, ill} = '0;
      asb = 2'b00; pcs = 2'b00; aop = 2'b00;
      case (st)
         0:     begin asb = 2'b01; irw = 1; pw = 1; end
         1:     begin asb = 2'b11; ill = (path_len(o) == 2); end
         2, 9:  begin asa = 1; asb = 2'b10; end
         3:     io = 1;
         4:     begin m2r = 1; rw = 1; end
         5:     begin io = 1; mw = 1; end
         6:     begin asa = 1; aop = 2'b10; end
         7:     begin rd = 1; rw = 1; end
         8:     begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
         10:    rw = 1;
         11:    begin pcs = 2'b10; pw = 1; end
         default: ;
      endcase
      if (aop == 2'b01)      alc = 3'b110;
      else if (aop == 2'b10) alc = (f == 6'b100010) ? 3'b110 : (f == 6'b100100) ? 3'b000 :
                                   (f == 6'b100101) ? 3'b001 : (f == 6'b101010) ? 3'b111 : 3'b010;
      else                   alc = 3'b010;
      if (rst) begin pw = 0; br = 0; mw = 0; irw = 0; rw = 0; ill = 0; end
      return {pw | (br & z), mw, irw, io, rd, m2r, rw, asa, asb, pcs, alc, ill};
   endfunction

   vec_t vt[$];

   initial begin
      //              rst op    funct zero st  pe mw irw io rd m2r rw asa asb    pcs    alc     ill
      vt.push_back(v(1, ADDI, 6'd0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, ADDI, 6'd0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, ADDI, 6'd0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
      vt.push_back(v(0, ADDI, 6'd0, 0, 9,  0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
      vt.push_back(v(0, ADDI, 6'd0, 0, 10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0));
      vt.push_back(v(0, SW,   6'd0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, SW,   6'd0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
      vt.push_back(v(0, SW,   6'd0, 0, 2,  0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
      vt.push_back(v(0, SW,   6'd0, 0, 5,  0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
      vt.push_back(v(0, BEQ,  6'd0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, BEQ,  6'd0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
      vt.push_back(v(0, BEQ,  6'd0, 1, 8,  1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
      vt.push_back(v(0, BEQ,  6'd0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, BEQ,  6'd0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
      vt.push_back(v(0, BEQ,  6'd0, 0, 8,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
      vt.push_back(v(0, RT,   SLT,  0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, RT,   SLT,  0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
      vt.push_back(v(0, RT,   SLT,  0, 6,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b111, 0));
      vt.push_back(v(0, RT,   SLT,  0, 7,  0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0));
      vt.push_back(v(0, RT,   FAND, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, RT,   FAND, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
      vt.push_back(v(0, RT,   FAND, 0, 6,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 0));
      vt.push_back(v(0, RT,   FAND, 0, 7,  0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0));
      vt.push_back(v(0, BAD,  6'd0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, BAD,  6'd0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1));
      vt.push_back(v(0, LW,   6'd0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, LW,   6'd0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
      vt.push_back(v(0, LW,   6'd0, 0, 2,  0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
      vt.push_back(v(1, LW,   6'd0, 0, 3,  0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
      vt.push_back(v(1, LW,   6'd0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, LW,   6'd0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
      vt.push_back(v(0, LW,   6'd0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));

      reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
      @(posedge clk); #1;
      foreach (vt[i]) begin
         reset = vt[i].rst; op = vt[i].op; funct = vt[i].funct; zero = vt[i].zero;
         #1;
         chk($sformatf("vec%0d state", i), 32'(dbg_state), 32'(vt[i].st));
         chk($sformatf("vec%0d outputs", i), 32'(obs()), 32'(vt[i].exp));
         @(posedge clk); #1;
      end

      // Random instruction stream with occasional mid-instruction reset.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int n = 0; n < 300; n++) begin
         logic [5:0] ops[6];
         logic [5:0] fns[5];
         int len, abort_at, irw_cnt, wr_cnt, st;
         bit aborted;
         ops = '{LW, SW, RT, BEQ, ADDI, JMP};
         fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
         if ($urandom_range(0, 7) == 0) begin
            op = 6'($urandom);
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         funct = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         len = path_len(op);
         abort_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         irw_cnt = 0; wr_cnt = 0; aborted = 0;
         for (int k = 0; k < len; k++) begin
            zero  = 1'($urandom);
            reset = (k == abort_at);
            #1;
            st = path_state(op, k);
            chk($sformatf("rnd%0d.%0d state", n, k), 32'(dbg_state), 32'(st));
            chk($sformatf("rnd%0d.%0d outputs op=%b", n, k, op), 32'(obs()),
                32'(model(st, op, funct, zero, reset)));
            irw_cnt += int'(irwrite);
            wr_cnt  += int'(memwrite) + int'(regwrite);
            @(posedge clk); #1;
            if (reset) begin
               reset = 1'b0;
               aborted = 1;
               break;
            end
         end
         if (!aborted) begin
            chk($sformatf("rnd%0d irwrite pulses", n), 32'(irw_cnt), 32'd1);
            chk($sformatf("rnd%0d at most one write", n), 32'(wr_cnt <= 1), 32'd1);
         end
      end
      #1;
      chk("final state fetch", 32'(dbg_state), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
